// File: rtl/lcd_fb_scanout.sv
// Framebuffer scan-out for a 4-bit STN LCD: fetches fbram bytes line by line,
// shifts them out as nibbles and generates CL1/CL2/FLM/M timing.
module lcd_fb_scanout #(
    parameter int H_BYTES   = 40,
    parameter int V_LINES   = 240,
    parameter int LP_CYCLES = 2,
    parameter int ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        fb_data,
    output logic              fb_clk,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [3:0]        data,
    output logic              dclk,
    output logic              lp,
    output logic              flm,
    output logic              m,
    output logic              frame_start
);
    localparam int CNT_W  = (LP_CYCLES > 4) ? $clog2(LP_CYCLES) : 2;
    localparam int BYTE_W = (H_BYTES > 1) ? $clog2(H_BYTES) : 1;
    localparam int LINE_W = (V_LINES > 1) ? $clog2(V_LINES) : 1;
    localparam logic [CNT_W-1:0]  LP_LAST   = CNT_W'(LP_CYCLES - 1);
    localparam logic [CNT_W-1:0]  PH_LAST   = CNT_W'(3);
    localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(H_BYTES - 1);
    localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(V_LINES - 1);
    localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(H_BYTES);

    typedef enum logic [1:0] {START, FETCH, SHIFT, LP} state_t;

    state_t            state, state_nx;
    logic [CNT_W-1:0]  cnt, cnt_nx;
    logic [BYTE_W-1:0] byte_idx, byte_nx;
    logic [LINE_W-1:0] line_idx, line_nx;
    logic [ADDR_W-1:0] base, base_nx;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        shift_buf;
    logic              m_q;
    logic              hold_q;
    logic              not_last;

    assign not_last = (byte_idx != BYTE_LAST);

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt + CNT_W'(1);
        byte_nx  = byte_idx;
        line_nx  = line_idx;
        base_nx  = base;
        case (state)
            START: if (cnt == LP_LAST) begin
                state_nx = FETCH;
                cnt_nx   = '0;
                line_nx  = '0;
                base_nx  = '0;
            end
            FETCH: if (cnt == PH_LAST) begin
                state_nx = SHIFT;
                cnt_nx   = '0;
                byte_nx  = '0;
            end
            SHIFT: if (cnt == PH_LAST) begin
                cnt_nx = '0;
                if (not_last) begin
                    byte_nx = byte_idx + BYTE_W'(1);
                end else begin
                    state_nx = (line_idx == LINE_LAST) ? START : LP;
                end
            end
            LP: if (cnt == LP_LAST) begin
                state_nx = FETCH;
                cnt_nx   = '0;
                line_nx  = line_idx + LINE_W'(1);
                base_nx  = base + LINE_STEP;
            end
        endcase
    end

    // Pin decode; hold_q blanks every output for the cycle following reset.
    always_comb begin
        fb_clk      = 1'b0;
        fb_addr     = addr_q;
        data        = 4'h0;
        dclk        = 1'b0;
        lp          = 1'b0;
        flm         = 1'b0;
        frame_start = 1'b0;
        m           = m_q & ~hold_q;
        if (hold_q) begin
            fb_addr = '0;
        end else begin
            case (state)
                START: begin
                    lp          = 1'b1;
                    flm         = 1'b1;
                    frame_start = (cnt == '0);
                end
                FETCH: begin
                    if (cnt == '0) fb_addr = base;
                    fb_clk = (cnt == CNT_W'(1));
                end
                SHIFT: begin
                    dclk = ~cnt[0];
                    data = cnt[1] ? shift_buf[3:0] : shift_buf[7:4];
                    if (not_last) begin
                        if (cnt == '0) fb_addr = base + ADDR_W'(byte_idx) + ADDR_W'(1);
                        fb_clk = (cnt == CNT_W'(1));
                    end
                end
                LP: lp = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q   <= 1'b1;
            state    <= START;
            cnt      <= '0;
            byte_idx <= '0;
            line_idx <= '0;
            base     <= '0;
            addr_q   <= '0;
            m_q      <= 1'b0;
        end else begin
            hold_q <= 1'b0;
            addr_q <= fb_addr;
            if (!hold_q) begin
                state    <= state_nx;
                cnt      <= cnt_nx;
                byte_idx <= byte_nx;
                line_idx <= line_nx;
                base     <= base_nx;
                if (state == SHIFT && state_nx == START) m_q <= ~m_q;
            end
        end
    end

    // Shift buffer is data only: loaded at F3, and at P3 for the prefetched byte.
    always_ff @(posedge clk) begin
        if (!hold_q && cnt == PH_LAST &&
            (state == FETCH || (state == SHIFT && not_last))) begin
            shift_buf <= fb_data;
        end
    end
endmodule

// File: doc/lcd_fb_scanout.md
Name: lcd_fb_scanout

Overview:
- Reader end of the framebuffer path. Font and HEX glyph logic writes monochrome pixels into the fbram; this block reads them back line by line.
- It serialises each framebuffer byte as two 4-bit nibbles onto the 4-bit STN LCD bus. It also generates the LCD control signals: dclk (CL2), lp (CL1), flm (first-line marker) and m (AC drive).
- It drives the fbram read port (fb_clk, fb_addr) and captures fb_data. It sits between fbram and the board LCD pins, clocked by the divided LCD clock.

Parameters:
- H_BYTES, 40, framebuffer bytes per line (320 px, 8 px per byte).
- V_LINES, 240, lines per frame.
- LP_CYCLES, 2, clk cycles that lp stays high per line pulse (minimum 1).
- ADDR_W, 32, width of fb_addr.

Ports:
- clk  input  1  LCD-domain clock; all logic on the rising edge.
- rst  input  1  synchronous reset, active high.
- fb_data  input  8  fbram read data; valid two clk cycles after fb_addr changes.
- fb_clk  output  1  fbram read strobe; one-cycle high pulse per byte fetch.
- fb_addr  output  ADDR_W  fbram read address, equal to line*H_BYTES + byte.
- data  output  4  LCD nibble; data[3] is the leftmost pixel.
- dclk  output  1  LCD shift clock (CL2); the panel latches data on the falling edge.
- lp  output  1  line latch pulse (CL1).
- flm  output  1  first-line marker, high only during the frame-start pulse.
- m  output  1  AC drive; toggles once per frame.
- frame_start  output  1  one-cycle pulse on the first cycle of each START state.

Behaviour:
- Reset:
  - While rst is high, all outputs are registered to 0 at the next edge: data, dclk, lp, flm, m, fb_clk, fb_addr and frame_start.
  - The state machine goes to START, with line=0 and byte=0.
  - The first cycle after rst falls is START cycle 0.
  - Reset mid-line aborts immediately. No partial lp pulse completes, and m returns to 0.
- FSM states: START, FETCH, SHIFT, LP.
- START (LP_CYCLES cycles):
  - lp=1, flm=1, dclk=0.
  - frame_start=1 in the first cycle only.
  - On entry from the last line, m toggles; the toggled value is visible in START cycle 0. Entry from reset does not toggle m.
  - Exits to FETCH with line=0.
- FETCH (4 cycles, F0..F3), with dclk=0 and lp=0:
  - F0: fb_addr = line*H_BYTES.
  - F1: fb_clk=1.
  - F2: fb_clk=0.
  - F3: capture fb_data into the shift buffer.
  - Exits to SHIFT with byte=0.
- SHIFT (4 cycles per byte, P0..P3):
  - P0: data = buffer[7:4], dclk=1.
  - P1: dclk=0.
  - P2: data = buffer[3:0], dclk=1.
  - P3: dclk=0.
  - Prefetch for byte b < H_BYTES-1:
    - P0: fb_addr = line*H_BYTES + b + 1.
    - P1: fb_clk=1.
    - P3: capture fb_data into the next-buffer.
    - The next-buffer moves to the shift buffer at the following P0.
  - No prefetch for the last byte: fb_clk stays 0 and fb_addr holds.
  - data holds its value through P1 and P3.
  - After P3 of byte H_BYTES-1: if line < V_LINES-1, go to LP; otherwise go to START.
- LP (LP_CYCLES cycles):
  - lp=1, flm=0, dclk=0, data=0.
  - Then line increments and the block goes to FETCH.
- Timing and counts:
  - Line period is 4 + 4*H_BYTES + LP_CYCLES clk cycles (166 at defaults).
  - Exactly H_BYTES lp pulses per frame are not the rule; the rule is V_LINES lp-high intervals per frame, counting START.
  - Exactly 2*H_BYTES dclk rising edges per line.
  - fb_clk pulses exactly H_BYTES times per line and never outside FETCH or SHIFT.
- Arithmetic and limits:
  - fb_addr is computed at ADDR_W bits, zero-extended; maximum value is H_BYTES*V_LINES-1 (9599).
  - The line counter wraps to 0 only through START.
  - dclk and lp are never high in the same cycle.

Test Plan:
- Reset, then release; fbram model has addr 0 = 0xA5, addr 1 = 0x3C -> START lp=flm=1 for 2 cycles with frame_start in cycle 0; FETCH fb_addr=0; data sequence 0xA,0x5,0x3,0xC on the dclk high cycles; m=0.
- Full line at defaults -> 80 dclk rising edges, 40 fb_clk pulses at addresses 0..39, then lp high for 2 cycles, then FETCH with fb_addr=40; line period 166 cycles.
- Full frame -> 239 LP pulses plus 1 START per frame; last fetch address 9599; flm high only in START; m toggles 0->1 at second START and 1->0 at third.
- Random fbram contents over 2 frames -> scoreboard reconstructs every pixel MSB-first per byte with zero mismatches; dclk&lp never 1 together.
- Assert rst for 1 cycle mid-SHIFT at line 100, byte 17 -> next cycle all outputs 0; after release, frame restarts at START, fb_addr=0, m=0.
- Parameters H_BYTES=2, V_LINES=3, LP_CYCLES=1 -> line period 13 cycles; frame = START(1) + 3 lines; addresses 0,1,2,3,4,5 in order.
